seg7_bcd_scanner: RTL

Parametrised successor to the fixed 4-digit counter/display block. It holds a DIGITS-wide BCD up/down counter, with one 4-bit BCD digit per display position. It time-multiplexes that counter onto a common-segment 7-segment display, with inter-digit ghost blanking, optional leading-zero suppression and configurable anode/segment polarity. It sits directly between board I/O (buttons, digit anodes, segment pins) and the top level, and needs no dividers.

---
 rtl/seg7_bcd_scanner.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_bcd_scanner.sv
// rtl/seg7_bcd_scanner.sv - BCD up/down counter time-multiplexed onto a common-segment 7-segment display
module seg7_bcd_scanner #(
  parameter int DIGITS           = 4,
  parameter int TICK_CYCLES      = 24_000_000,
  parameter int SCAN_CYCLES      = 120_000,
  parameter int BLANK_CYCLES     = 1_200,
  parameter bit LZ_BLANK         = 1'b1,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b0
) (
  input  logic                clk,
  input  logic                user_btn,
  input  logic                count_en,
  input  logic                up_down,
  input  logic                clear,
  output logic [DIGITS-1:0]   anode,
  output logic [6:0]          seg,
  output logic                wrap,
  output logic [4*DIGITS-1:0] value
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int TW = $clog2(SCAN_CYCLES);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] T_BLANK_LAST = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] T_SCAN_LAST = TW'(SCAN_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic {S_BLANK, S_SHOW} scan_state_t;

  logic [PW-1:0]       r_presc;
  logic [4*DIGITS-1:0] r_value;
  logic [4*DIGITS-1:0] w_value_next;
  logic                r_wrap;
  logic                w_step;
  logic                w_carry;

  scan_state_t         r_state, w_state_next;
  logic [TW-1:0]       r_t, w_t_next;
  logic [IW-1:0]       r_idx, w_idx_next;
  logic [DIGITS-1:0]   r_anode, w_anode_next;
  logic [6:0]          r_seg, w_seg_next;
  logic [DIGITS-1:0]   w_lz;
  logic [3:0]          w_digit;
  logic                w_blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = 7'b0000000;
    endcase
  endfunction

  assign w_step = count_en && (r_presc == PRESC_LAST);

  // w_carry doubles as borrow when counting down; it survives the loop only on full wrap.
  always_comb begin
    w_value_next = r_value;
    w_carry      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (up_down) begin
          if (r_value[4*i +: 4] == 4'd9) begin
            w_value_next[4*i +: 4] = 4'd0;
          end else begin
            w_value_next[4*i +: 4] = r_value[4*i +: 4] + 4'd1;
            w_carry = 1'b0;
          end
        end else begin
          if (r_value[4*i +: 4] == 4'd0) begin
            w_value_next[4*i +: 4] = 4'd9;
          end else begin
            w_value_next[4*i +: 4] = r_value[4*i +: 4] - 4'd1;
            w_carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge user_btn) begin
    if (!user_btn) begin
      r_presc <= '0;
      r_value <= '0;
      r_wrap  <= 1'b0;
    end else if (clear) begin
      r_presc <= '0;
      r_value <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= w_step && w_carry;
      if (count_en) begin
        r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
      end
      if (w_step) begin
        r_value <= w_value_next;
      end
    end
  end

  // w_lz[i] is set when digit i and every digit above it are zero.
  always_comb begin
    w_lz = '0;
    w_lz[DIGITS-1] = (r_value[4*DIGITS-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      w_lz[i] = w_lz[i+1] && (r_value[4*i +: 4] == 4'd0);
    end
  end

  always_comb begin
    w_digit = 4'd0;
    w_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_digit = r_value[4*i +: 4];
        w_blank = LZ_BLANK && (i > 0) && w_lz[i];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_t_next     = r_t + 1'b1;
    w_idx_next   = r_idx;
    w_anode_next = r_anode;
    w_seg_next   = r_seg;
    case (r_state)
      S_BLANK: begin
        if (r_t == T_BLANK_LAST) begin
          w_state_next = S_SHOW;
          if (!w_blank) begin
            w_anode_next = DIGITS'(1) << r_idx;
            w_seg_next   = decode(w_digit);
          end
        end
      end
      S_SHOW: begin
        if (r_t == T_SCAN_LAST) begin
          w_state_next = S_BLANK;
          w_t_next     = '0;
          w_idx_next   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          w_anode_next = '0;
          w_seg_next   = '0;
        end
      end
      default: begin
        w_state_next = S_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or negedge user_btn) begin
    if (!user_btn) begin
      r_state <= S_BLANK;
      r_t     <= '0;
      r_idx   <= '0;
      r_anode <= '0;
      r_seg   <= '0;
    end else begin
      r_state <= w_state_next;
      r_t     <= w_t_next;
      r_idx   <= w_idx_next;
      r_anode <= w_anode_next;
      r_seg   <= w_seg_next;
    end
  end

  assign anode = ANODE_ACTIVE_LOW ? ~r_anode : r_anode;
  assign seg   = SEG_ACTIVE_LOW ? ~r_seg : r_seg;
  assign wrap  = r_wrap;
  assign value = r_value;

endmodule
